// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Stall vector bit order: 0=pc 1=if 2=id 3=ex 4=mem 5=wb.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    PCTRL_IDLE   = 2'd0,
    PCTRL_MC_RUN = 2'd1,
    PCTRL_FLUSH  = 2'd2
  } pctrl_state_e;

  // Combinational command bundle produced every cycle.
  typedef struct packed {
    logic [STALL_W-1:0] stall;
    logic               mc_start;
    logic               mc_cancel;
  } pctrl_cmd_t;

  localparam pctrl_cmd_t CMD_NONE = '{stall: STALL_NONE, mc_start: 1'b0, mc_cancel: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Core <-> scheduler bundle: hazard/event requests in, stall/flush/divider control out.
// master = scheduler side, slave = core side.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic               stallreq_id_i;
  logic               ex_mc_req_i;
  logic               mc_ready_i;
  logic               flush_req_i;
  logic [31:0]        flush_pc_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_o;
  logic [31:0]        new_pc_o;
  logic               mc_start_o;
  logic               mc_cancel_o;
  logic               mc_timeout_o;
  logic [31:0]        stall_cnt_o;

  modport master (
    input  stallreq_id_i, ex_mc_req_i, mc_ready_i, flush_req_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o, mc_start_o, mc_cancel_o, mc_timeout_o, stall_cnt_o
  );

  modport slave (
    output stallreq_id_i, ex_mc_req_i, mc_ready_i, flush_req_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, mc_start_o, mc_cancel_o, mc_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter: increments when en is high, sticks at all-ones.
module pipe_ctrl_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage core: flush > multi-cycle EX > load-use.
// Sequences divider start/cancel and forces a cancel after MC_TIMEOUT busy cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W   = 6,
  parameter int MC_TIMEOUT = 40   // must stay below 2**MC_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);
  pctrl_state_e        state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         new_pc_q, new_pc_d;
  logic                timeout_q, timeout_d;
  pctrl_cmd_t          cmd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    new_pc_d  = new_pc_q;
    timeout_d = timeout_q;
    cmd       = CMD_NONE;

    case (state_q)
      PCTRL_IDLE: begin
        if (bus.flush_req_i) begin
          state_d  = PCTRL_FLUSH;
          new_pc_d = bus.flush_pc_i;
        end else if (bus.ex_mc_req_i) begin
          cmd.mc_start = 1'b1;
          cmd.stall    = STALL_EX;
          cnt_d        = '0;
          state_d      = PCTRL_MC_RUN;
        end else if (bus.stallreq_id_i) begin
          cmd.stall = STALL_ID;
        end
      end

      PCTRL_MC_RUN: begin
        // Load-use requests are subsumed by the EX hold, so they are not examined here.
        cmd.stall = STALL_EX;
        cnt_d     = cnt_q + MC_CNT_W'(1);
        if (bus.flush_req_i) begin
          cmd.mc_cancel = ~bus.mc_ready_i;
          new_pc_d      = bus.flush_pc_i;
          state_d       = PCTRL_FLUSH;
        end else if (bus.mc_ready_i) begin
          cmd.stall = STALL_NONE;
          state_d   = PCTRL_IDLE;
        end else if (cnt_q == MC_CNT_W'(MC_TIMEOUT - 1)) begin
          cmd.stall     = STALL_NONE;
          cmd.mc_cancel = 1'b1;
          timeout_d     = 1'b1;
          state_d       = PCTRL_IDLE;
        end
      end

      PCTRL_FLUSH: begin
        if (bus.flush_req_i) new_pc_d = bus.flush_pc_i;
        else                 state_d  = PCTRL_IDLE;
      end

      default: state_d = PCTRL_IDLE;
    endcase

    // Reset silences every combinational strobe; the divider shares the same reset.
    if (rst) cmd = CMD_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PCTRL_IDLE;
      cnt_q     <= '0;
      new_pc_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      new_pc_q  <= new_pc_d;
      timeout_q <= timeout_d;
    end
  end

  pipe_ctrl_sat_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (|cmd.stall),
    .cnt_o (bus.stall_cnt_o)
  );

  assign bus.stall_o      = cmd.stall;
  assign bus.mc_start_o   = cmd.mc_start;
  assign bus.mc_cancel_o  = cmd.mc_cancel;
  assign bus.flush_o      = (state_q == PCTRL_FLUSH);
  assign bus.new_pc_o     = new_pc_q;
  assign bus.mc_timeout_o = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares every output.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.MC_CNT_W(6), .MC_TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        start;
    logic        cancel;
    logic        flush;
    logic [31:0] pc;
    logic        to;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] e_pc = '0;
  logic        e_to = 1'b0;
  logic [31:0] e_sc = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  task automatic drive(input logic rs, input logic sid, input logic mc, input logic rdy,
                       input logic fl, input logic [31:0] pc);
    @(posedge clk); #1;
    rst               = rs;
    bus.stallreq_id_i = sid;
    bus.ex_mc_req_i   = mc;
    bus.mc_ready_i    = rdy;
    bus.flush_req_i   = fl;
    bus.flush_pc_i    = pc;
  endtask

  // Expected outputs for the cycle just driven; stall counter advances on nonzero stall.
  task automatic expect_c(input logic [5:0] st, input logic s, input logic c, input logic f);
    exp_t e;
    e.stall = st; e.start = s; e.cancel = c; e.flush = f;
    e.pc = e_pc; e.to = e_to; e.sc = e_sc;
    q.push_back(e);
    if (st != 6'd0) e_sc = e_sc + 32'd1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall_o",      32'(bus.stall_o),      32'(e.stall));
        chk("mc_start_o",   32'(bus.mc_start_o),   32'(e.start));
        chk("mc_cancel_o",  32'(bus.mc_cancel_o),  32'(e.cancel));
        chk("flush_o",      32'(bus.flush_o),      32'(e.flush));
        chk("new_pc_o",     bus.new_pc_o,          e.pc);
        chk("mc_timeout_o", 32'(bus.mc_timeout_o), 32'(e.to));
        chk("stall_cnt_o",  bus.stall_cnt_o,       e.sc);
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    bus.stallreq_id_i = 1'b1; bus.ex_mc_req_i = 1'b1; bus.mc_ready_i = 1'b1;
    bus.flush_req_i = 1'b1;   bus.flush_pc_i = '1;

    // Reset with every input asserted
    repeat (2) begin drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF); expect_c(STALL_NONE, 0, 0, 0); end
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // Load-use stall for 3 cycles
    repeat (3) begin drive(0, 1, 0, 0, 0, 0); expect_c(STALL_ID, 0, 0, 0); end
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // Divider op completing 34 cycles after the start
    drive(0, 0, 1, 0, 0, 0); expect_c(STALL_EX, 1, 0, 0);
    for (int i = 0; i < 33; i++) begin drive(0, 0, 0, 0, 0, 0); expect_c(STALL_EX, 0, 0, 0); end
    drive(0, 0, 0, 1, 0, 0); expect_c(STALL_NONE, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // Flush during MC_RUN cancels the divider
    drive(0, 0, 1, 0, 0, 0); expect_c(STALL_EX, 1, 0, 0);
    repeat (2) begin drive(0, 0, 0, 0, 0, 0); expect_c(STALL_EX, 0, 0, 0); end
    drive(0, 0, 0, 0, 1, 32'hBFC0_0380); expect_c(STALL_EX, 0, 1, 0);
    e_pc = 32'hBFC0_0380;
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // Flush coinciding with ready: no cancel; back-to-back flush relatches PC
    drive(0, 0, 1, 0, 0, 0); expect_c(STALL_EX, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_EX, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h0000_0100); expect_c(STALL_EX, 0, 0, 0);
    e_pc = 32'h0000_0100;
    drive(0, 0, 1, 0, 1, 32'h0000_0200); expect_c(STALL_NONE, 0, 0, 1);
    e_pc = 32'h0000_0200;
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // Timeout on cycle 40 of MC_RUN; load-use ignored while running
    drive(0, 0, 1, 0, 0, 0); expect_c(STALL_EX, 1, 0, 0);
    for (int k = 1; k < 40; k++) begin drive(0, 1, 0, 0, 0, 0); expect_c(STALL_EX, 0, 0, 0); end
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 1, 0);
    e_to = 1'b1;
    drive(0, 1, 0, 0, 0, 0); expect_c(STALL_ID, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // All three requests together in IDLE: flush wins
    drive(0, 1, 1, 0, 1, 32'hDEAD_0000); expect_c(STALL_NONE, 0, 0, 0);
    e_pc = 32'hDEAD_0000;
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    // Reset mid-MC_RUN: no cancel pulse, everything cleared
    drive(0, 0, 1, 0, 0, 0); expect_c(STALL_EX, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_EX, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h0000_0055); expect_c(STALL_NONE, 0, 0, 0);
    e_pc = '0; e_to = 1'b0; e_sc = '0;
    drive(0, 0, 0, 0, 0, 0); expect_c(STALL_NONE, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
